// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Drives the four Go Board LEDs through one of four step patterns: BLINK,
//   CHASE, BOUNCE or BINARY. A free-running prescaler sets the step rate.
//   Switch 1 selects the next pattern. Switch 2 pauses and resumes stepping.
//   Both switches pass through a 2-flop synchroniser and a debounce counter.
// Ports
//   i_Clk              system clock
//   i_Rst              asynchronous reset, active-high
//   i_Switch_1         raw pushbutton; a press moves to the next mode
//   i_Switch_2         raw pushbutton; a press toggles run/pause
//   o_LED_1..o_LED_4   registered LED drives
//   o_Mode             current mode: 0 BLINK, 1 CHASE, 2 BOUNCE, 3 BINARY
//   o_Running          1 while stepping, 0 while paused
module led_pattern_sequencer #(
    parameter int unsigned COUNT          = 12500000,
    parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic [1:0] o_Mode,
    output logic       o_Running
);

    localparam int unsigned COUNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int unsigned DB_W    = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BINARY = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    function automatic logic [3:0] onehot4(input logic [1:0] p);
        return 4'b0001 << p;
    endfunction

    // ------------------------------------------------------------------
    // Switch conditioning: bit 0 = Switch_1 (mode), bit 1 = Switch_2 (pause)
    // ------------------------------------------------------------------
    logic [1:0]      sw_raw;
    logic [1:0]      sw_meta;
    logic [1:0]      sw_sync;
    logic [1:0]      sw_stable;
    logic [1:0]      sw_flip;
    logic [1:0]      sw_press;
    logic [DB_W-1:0] db_cnt [2];

    assign sw_raw = {i_Switch_2, i_Switch_1};

    // A flip is accepted on the edge the counter has already seen LIMIT-1
    // differing samples and the current sample still differs.
    always_comb begin
        sw_flip  = '0;
        sw_press = '0;
        for (int i = 0; i < 2; i++) begin
            sw_flip[i]  = (sw_sync[i] != sw_stable[i]) &&
                          (db_cnt[i] == DB_W'(DEBOUNCE_LIMIT - 1));
            sw_press[i] = (sw_sync[i] != sw_stable[i]) &&
                          (db_cnt[i] == DB_W'(DEBOUNCE_LIMIT - 1)) &&
                          !sw_stable[i];
        end
    end

    // Synchroniser and debounce registers
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sw_meta   <= '0;
            sw_sync   <= '0;
            sw_stable <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sw_meta <= sw_raw;
            sw_sync <= sw_meta;
            for (int i = 0; i < 2; i++) begin
                if (sw_flip[i]) begin
                    sw_stable[i] <= ~sw_stable[i];
                    db_cnt[i]    <= '0;
                end else if (sw_sync[i] != sw_stable[i]) begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    mode_t              mode_q,    mode_d;
    dir_t               dir_q,     dir_d;
    logic               running_q, running_d;
    logic [COUNT_W-1:0] count_q,   count_d;
    logic               step_q,    step_d;
    logic [1:0]         pos_q,     pos_d;
    logic               phase_q,   phase_d;
    logic [3:0]         bin_q,     bin_d;
    logic [3:0]         leds_q,    leds_d;

    // State register
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            mode_q    <= MODE_BLINK;
            dir_q     <= DIR_UP;
            running_q <= 1'b1;
            count_q   <= '0;
            step_q    <= 1'b0;
            pos_q     <= 2'd0;
            phase_q   <= 1'b0;
            bin_q     <= 4'd0;
            leds_q    <= 4'd0;
        end else begin
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            running_q <= running_d;
            count_q   <= count_d;
            step_q    <= step_d;
            pos_q     <= pos_d;
            phase_q   <= phase_d;
            bin_q     <= bin_d;
            leds_q    <= leds_d;
        end
    end

    // Next state: a mode press restarts the pattern and discards a pending
    // step; otherwise the prescaler runs and a pending step is applied.
    always_comb begin
        mode_d    = mode_q;
        dir_d     = dir_q;
        running_d = running_q;
        count_d   = count_q;
        step_d    = 1'b0;
        pos_d     = pos_q;
        phase_d   = phase_q;
        bin_d     = bin_q;
        leds_d    = leds_q;

        if (sw_press[1]) begin
            running_d = ~running_q;
        end

        if (sw_press[0]) begin
            mode_d  = mode_t'(2'(mode_q + 2'd1));
            count_d = '0;
            pos_d   = 2'd0;
            dir_d   = DIR_UP;
            phase_d = 1'b0;
            bin_d   = 4'd0;
            leds_d  = (mode_d == MODE_CHASE || mode_d == MODE_BOUNCE) ? 4'b0001 : 4'b0000;
        end else begin
            if (running_q) begin
                if (count_q == COUNT_W'(COUNT - 1)) begin
                    count_d = '0;
                    step_d  = 1'b1;
                end else begin
                    count_d = count_q + COUNT_W'(1);
                end
            end

            if (step_q) begin
                case (mode_q)
                    MODE_BLINK: begin
                        phase_d = ~phase_q;
                        leds_d  = {4{~phase_q}};
                    end
                    MODE_CHASE: begin
                        pos_d  = pos_q + 2'd1;
                        leds_d = onehot4(pos_q + 2'd1);
                    end
                    MODE_BOUNCE: begin
                        // Reverse at either end without repeating the end LED
                        if (dir_q == DIR_UP) begin
                            if (pos_q == 2'd3) begin
                                pos_d = 2'd2;
                                dir_d = DIR_DOWN;
                            end else begin
                                pos_d = pos_q + 2'd1;
                            end
                        end else begin
                            if (pos_q == 2'd0) begin
                                pos_d = 2'd1;
                                dir_d = DIR_UP;
                            end else begin
                                pos_d = pos_q - 2'd1;
                            end
                        end
                        leds_d = onehot4(pos_d);
                    end
                    MODE_BINARY: begin
                        bin_d  = bin_q + 4'd1;
                        leds_d = bin_q + 4'd1;
                    end
                    default: begin
                        leds_d = leds_q;
                    end
                endcase
            end
        end
    end

    assign o_LED_1   = leds_q[0];
    assign o_LED_2   = leds_q[1];
    assign o_LED_3   = leds_q[2];
    assign o_LED_4   = leds_q[3];
    assign o_Mode    = mode_q;
    assign o_Running = running_q;

endmodule
